// File: rtl/sm83_pkg.sv
// Shared definitions for the SM83 interrupt controller: register addresses,
// bus/request types, source indices and the address decoder.
package sm83_pkg;

  localparam int NUM_IRQS = 8;
  localparam int NUM_SRCS = 5;

  typedef logic [7:0]          word_t;
  typedef logic [15:0]         adr_t;
  typedef logic [NUM_IRQS-1:0] irq_t;

  localparam adr_t ADR_IF = 16'hFF0F;
  localparam adr_t ADR_IE = 16'hFFFF;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  // Which controller register an address selects.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_IE   = 2'd2
  } reg_sel_e;

  // Exact 16-bit match; every other address maps to nothing.
  function automatic reg_sel_e decode_adr(adr_t a);
    if (a == ADR_IF) return SEL_IF;
    if (a == ADR_IE) return SEL_IE;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/sm83_int_ctl_if.sv
// CPU-side register bus of the interrupt controller.
// master = CPU side, slave = controller side.
interface sm83_int_ctl_if;
  import sm83_pkg::*;

  adr_t  adr;
  word_t din;
  word_t dout;
  logic  dout_oe;
  logic  p_rd;
  logic  p_wr;

  modport master (output adr, din, p_rd, p_wr, input dout, dout_oe);
  modport slave  (input adr, din, p_rd, p_wr, output dout, dout_oe);
endinterface

// File: rtl/sm83_int_edge.sv
// Per-source rising-edge detector.
// Build option SM83_INT_SRC_SYNC_EN: when defined, each source first passes a
// 2-flop synchronizer (two extra cycles of latency). During reset every flop
// loads the live source value so a level held across reset gives no edge.
module sm83_int_edge #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sampled;

`ifdef SM83_INT_SRC_SYNC_EN
  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;

  // Two-stage synchronizer, preloaded with the current sources in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= src;
      sync2_reg <= src;
    end else begin
      sync1_reg <= src;
      sync2_reg <= sync1_reg;
    end
  end

  assign sampled = sync2_reg;
`else
  assign sampled = src;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic prev_reg;

      // Previous-sample history for this source bit.
      always_ff @(posedge clk) begin
        if (reset) prev_reg <= src[gi];
        else       prev_reg <= sampled[gi];
      end

      assign rise[gi] = sampled[gi] & ~prev_reg;
    end
  endgenerate

endmodule

// File: rtl/sm83_int_ctl.sv
// SM83 interrupt controller: IF (0xFF0F) and IE (0xFFFF) registers, write
// latch committed on the falling p_wr, edge-triggered sources, one-hot
// acknowledge and irq = IF & IE. Source synchronizer is enabled by the
// SM83_INT_SRC_SYNC_EN build macro (see sm83_int_edge).
module sm83_int_ctl
  import sm83_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  sm83_int_ctl_if.slave       bus,
  input  logic [NUM_SRCS-1:0] src,
  output irq_t                irq,
  input  irq_t                iack
);

  logic [NUM_SRCS-1:0] if_reg, if_next;
  word_t               ie_reg, ie_next;
  logic [NUM_SRCS-1:0] src_rise;

  logic     wact_reg;
  reg_sel_e wsel_reg;
  word_t    wdata_reg;
  logic     commit;
  reg_sel_e rd_sel;

  // Acknowledge bits above the implemented sources are ignored.
  logic unused_iack;
  assign unused_iack = ^iack[NUM_IRQS-1:NUM_SRCS];

  sm83_int_edge #(.WIDTH(NUM_SRCS)) u_edge (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .rise  (src_rise)
  );

  // Write latch: track data/target while p_wr is high; reset discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wact_reg  <= 1'b0;
      wsel_reg  <= SEL_NONE;
      wdata_reg <= '0;
    end else if (bus.p_wr) begin
      wact_reg  <= 1'b1;
      wsel_reg  <= decode_adr(bus.adr);
      wdata_reg <= bus.din;
    end else begin
      wact_reg  <= 1'b0;
    end
  end

  // The first low cycle after a write burst commits the latched value.
  assign commit = wact_reg & ~bus.p_wr;

  // Register update: write, then acknowledge clears, then source edges set.
  always_comb begin
    if_next = if_reg;
    ie_next = ie_reg;
    if (commit && wsel_reg == SEL_IF) if_next = wdata_reg[NUM_SRCS-1:0];
    if (commit && wsel_reg == SEL_IE) ie_next = wdata_reg;
    if_next = (if_next & ~iack[NUM_SRCS-1:0]) | src_rise;
  end

  // IF/IE state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_reg <= '0;
      ie_reg <= '0;
    end else begin
      if_reg <= if_next;
      ie_reg <= ie_next;
    end
  end

  // Requests come only from registered IF/IE, never directly from src.
  assign irq = {{(NUM_IRQS-NUM_SRCS){1'b0}}, if_reg & ie_reg[NUM_SRCS-1:0]};

  assign rd_sel = decode_adr(bus.adr);

  // Read mux: drive data only while a mapped register is being read.
  always_comb begin
    bus.dout_oe = 1'b0;
    bus.dout    = '0;
    if (bus.p_rd) begin
      case (rd_sel)
        SEL_IF: begin
          bus.dout_oe = 1'b1;
          bus.dout    = {3'b111, if_reg};
        end
        SEL_IE: begin
          bus.dout_oe = 1'b1;
          bus.dout    = ie_reg;
        end
        default: begin
          bus.dout_oe = 1'b0;
          bus.dout    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm83_int_ctl.sv
// Self-checking bench for sm83_int_ctl: directed scenarios plus a randomized
// run, all compared against a sample-history reference model.
module tb_sm83_int_ctl;
  import sm83_pkg::*;

`ifdef SM83_INT_SRC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] src;
  irq_t       irq;
  irq_t       iack;

  sm83_int_ctl_if bus();

  sm83_int_ctl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .src   (src),
    .irq   (irq),
    .iack  (iack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [4:0] m_if;
  word_t      m_ie;
  bit         m_wact;
  adr_t       m_wadr;
  word_t      m_wdata;
  logic [4:0] hist[$];   // hist[0] = newest src sample

  // Model: a rising source is seen LAT samples late; writes commit on the
  // first idle cycle after a write burst; the edge always wins.
  always @(posedge clk) begin
    logic [4:0] e;
    logic [4:0] base;
    word_t      ie_new;
    hist.push_front(src);
    if (reset) begin
      m_if = 5'h00;
      m_ie = 8'h00;
      m_wact = 1'b0;
      hist.delete();
      repeat (LAT + 2) hist.push_back(src);
    end else begin
      e = (hist.size() >= LAT + 2) ? (hist[LAT] & ~hist[LAT+1]) : 5'h00;
      base = m_if;
      ie_new = m_ie;
      if (!bus.p_wr && m_wact) begin
        if (m_wadr == ADR_IF) base = m_wdata[4:0];
        else if (m_wadr == ADR_IE) ie_new = m_wdata;
        m_wact = 1'b0;
      end
      if (bus.p_wr) begin
        m_wact = 1'b1;
        m_wadr = bus.adr;
        m_wdata = bus.din;
      end
      m_if = (base & ~iack[4:0]) | e;
      m_ie = ie_new;
    end
    while (hist.size() > LAT + 2) void'(hist.pop_back());
  end

  function automatic word_t exp_dout();
    if (bus.p_rd && bus.adr == ADR_IF) return {3'b111, m_if};
    if (bus.p_rd && bus.adr == ADR_IE) return m_ie;
    return 8'h00;
  endfunction

  function automatic logic exp_oe();
    return bus.p_rd && (bus.adr == ADR_IF || bus.adr == ADR_IE);
  endfunction

  function automatic irq_t exp_irq();
    return {3'b000, m_if & m_ie[4:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cpu_write(input adr_t a, input word_t d);
    bus.adr = a; bus.din = d; bus.p_wr = 1'b1;
    step();
    bus.p_wr = 1'b0;
    step();
  endtask

  task automatic settle_src(input logic [4:0] v);
    src = v;
    repeat (LAT + 2) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (irq !== 8'h00) $display("FAIL reset_irq: got %h want 00", irq); else n_pass++;
    bus.p_rd = 1'b1; bus.adr = ADR_IF; #1;
    n_checks++; if (bus.dout !== 8'hE0 || bus.dout_oe !== 1'b1)
      $display("FAIL reset_rd_if: got %h/%b want e0/1", bus.dout, bus.dout_oe); else n_pass++;
    bus.adr = ADR_IE; #1;
    n_checks++; if (bus.dout !== 8'h00 || bus.dout_oe !== 1'b1)
      $display("FAIL reset_rd_ie: got %h/%b want 00/1", bus.dout, bus.dout_oe); else n_pass++;
    reset = 1'b0; bus.p_rd = 1'b0; #1;
    n_checks++; if (bus.dout !== 8'h00 || bus.dout_oe !== 1'b0)
      $display("FAIL idle_bus: got %h/%b want 00/0", bus.dout, bus.dout_oe); else n_pass++;
    step();
    $display("test_reset done");
  endtask

  task automatic test_ie_src();
    int cnt;
    settle_src(5'h00);
    cpu_write(ADR_IE, 8'h04);
    src = 5'h04;
    cnt = 0;
    while (cnt < 8) begin
      step();
      cnt++;
      if (irq === 8'h04) break;
    end
    n_checks++; if (irq !== 8'h04 || cnt != LAT + 1)
      $display("FAIL src_latency: irq %h after %0d cycles want 04 after %0d", irq, cnt, LAT + 1);
    else n_pass++;
    bus.p_rd = 1'b1; bus.adr = ADR_IF; #1;
    n_checks++; if (bus.dout !== 8'hE4) $display("FAIL src_rd_if: got %h want e4", bus.dout); else n_pass++;
    bus.p_rd = 1'b0;
    $display("test_ie_src done");
  endtask

  task automatic test_iack();
    settle_src(5'h00);
    cpu_write(ADR_IF, 8'h05);
    cpu_write(ADR_IE, 8'h1F);
    n_checks++; if (irq !== 8'h05) $display("FAIL iack_pre: got %h want 05", irq); else n_pass++;
    iack = 8'h01; step(); iack = 8'h00;
    n_checks++; if (irq !== 8'h04) $display("FAIL iack_clear: got %h want 04", irq); else n_pass++;
    iack = 8'hE4; src = 5'h04; step(); iack = 8'h00;
    bus.p_rd = 1'b1; bus.adr = ADR_IF; #1;
    n_checks++; if (bus.dout !== exp_dout())
      $display("FAIL iack_vs_edge: got %h want %h", bus.dout, exp_dout()); else n_pass++;
    repeat (3) step();
    n_checks++; if (bus.dout !== 8'hE4) $display("FAIL iack_edge_final: got %h want e4", bus.dout); else n_pass++;
    bus.p_rd = 1'b0;
    $display("test_iack done");
  endtask

  task automatic test_if_ie();
    settle_src(5'h00);
    cpu_write(ADR_IE, 8'h00);
    cpu_write(ADR_IF, 8'h1F);
    n_checks++; if (irq !== 8'h00) $display("FAIL if_only: got %h want 00", irq); else n_pass++;
    bus.adr = ADR_IE; bus.din = 8'h10; bus.p_wr = 1'b1;
    step();
    n_checks++; if (irq !== 8'h00) $display("FAIL ie_precommit: got %h want 00", irq); else n_pass++;
    bus.p_wr = 1'b0;
    step();
    n_checks++; if (irq !== 8'h10) $display("FAIL ie_commit: got %h want 10", irq); else n_pass++;
    cpu_write(ADR_IE, 8'h00);
    bus.p_rd = 1'b1; bus.adr = ADR_IF; #1;
    n_checks++; if (irq !== 8'h00 || bus.dout !== 8'hFF)
      $display("FAIL ie_clear: irq %h if %h want 00/ff", irq, bus.dout); else n_pass++;
    bus.p_rd = 1'b0;
    $display("test_if_ie done");
  endtask

  task automatic test_reset_hold();
    src = 5'h1F;
    reset = 1'b1; step(); step();
    reset = 1'b0;
    repeat (4) step();
    bus.p_rd = 1'b1; bus.adr = ADR_IF; #1;
    n_checks++; if (bus.dout !== 8'hE0) $display("FAIL held_src: got %h want e0", bus.dout); else n_pass++;
    bus.p_rd = 1'b0;
    bus.adr = ADR_IE; bus.din = 8'hFF; bus.p_wr = 1'b1;
    step();
    reset = 1'b1; step();
    reset = 1'b0; bus.p_wr = 1'b0;
    step(); step();
    bus.p_rd = 1'b1; bus.adr = ADR_IE; #1;
    n_checks++; if (bus.dout !== 8'h00) $display("FAIL wr_discard: got %h want 00", bus.dout); else n_pass++;
    bus.p_rd = 1'b0;
    $display("test_reset_hold done");
  endtask

  task automatic test_unmapped();
    settle_src(5'h00);
    cpu_write(ADR_IE, 8'h15);
    cpu_write(ADR_IF, 8'h0A);
    bus.p_rd = 1'b1; bus.adr = 16'hFF10; #1;
    n_checks++; if (bus.dout_oe !== 1'b0 || bus.dout !== 8'h00)
      $display("FAIL unmapped_rd: got %h/%b want 00/0", bus.dout, bus.dout_oe); else n_pass++;
    bus.p_rd = 1'b0;
    cpu_write(16'hFF0E, 8'hFF);
    bus.p_rd = 1'b1; bus.adr = ADR_IF; #1;
    n_checks++; if (bus.dout !== 8'hEA) $display("FAIL unmapped_wr_if: got %h want ea", bus.dout); else n_pass++;
    bus.adr = ADR_IE; #1;
    n_checks++; if (bus.dout !== 8'h15) $display("FAIL unmapped_wr_ie: got %h want 15", bus.dout); else n_pass++;
    bus.p_rd = 1'b0;
    $display("test_unmapped done");
  endtask

  task automatic test_rd_wr_same();
    bus.p_rd = 1'b1; bus.p_wr = 1'b1; bus.adr = ADR_IE; bus.din = 8'h0A; #1;
    n_checks++; if (bus.dout !== 8'h15) $display("FAIL rdwr_old: got %h want 15", bus.dout); else n_pass++;
    step();
    n_checks++; if (bus.dout !== 8'h15) $display("FAIL rdwr_hold: got %h want 15", bus.dout); else n_pass++;
    bus.p_wr = 1'b0;
    step();
    n_checks++; if (bus.dout !== 8'h0A) $display("FAIL rdwr_new: got %h want 0a", bus.dout); else n_pass++;
    bus.p_rd = 1'b0;
    $display("test_rd_wr_same done");
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = n_checks - n_pass;
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 63) == 0);
      src      = 5'($urandom);
      bus.p_wr = ($urandom_range(0, 2) == 0);
      bus.p_rd = ($urandom_range(0, 1) == 0);
      bus.din  = 8'($urandom);
      iack     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      case ($urandom_range(0, 4))
        0:       bus.adr = ADR_IF;
        1:       bus.adr = ADR_IE;
        2:       bus.adr = 16'hFF10;
        3:       bus.adr = 16'hFF0E;
        default: bus.adr = 16'($urandom);
      endcase
      #1;
      n_checks++; if (bus.dout !== exp_dout())
        $display("FAIL rand_dout[%0d]: got %h want %h", i, bus.dout, exp_dout()); else n_pass++;
      n_checks++; if (bus.dout_oe !== exp_oe())
        $display("FAIL rand_oe[%0d]: got %b want %b", i, bus.dout_oe, exp_oe()); else n_pass++;
      n_checks++; if (irq !== exp_irq())
        $display("FAIL rand_irq[%0d]: got %h want %h", i, irq, exp_irq()); else n_pass++;
      step();
    end
    reset = 1'b0; bus.p_wr = 1'b0; bus.p_rd = 1'b0; iack = 8'h00;
    $display("test_random done: %0d new failures", (n_checks - n_pass) - errs_before);
  endtask

  initial begin
    reset = 1'b1; src = 5'h00; iack = 8'h00;
    bus.adr = 16'h0000; bus.din = 8'h00; bus.p_rd = 1'b0; bus.p_wr = 1'b0;
    @(negedge clk);
    test_reset();
    test_ie_src();
    test_iack();
    test_if_ie();
    test_reset_hold();
    test_unmapped();
    test_rd_wr_same();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
